// File: rtl/crypto_wallet2_nios_po_seed_bank.sv
// Avalon-MM seed bank: staged words committed atomically to a wide out_port.
// Define SEED_BANK_READBACK_EN to let staging words read back over the bus.
module crypto_wallet2_nios_po_seed_bank #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WORDS  = 2,
   parameter int ADDR_WIDTH = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [ADDR_WIDTH-1:0]           address,
   input  logic                            chipselect,
   input  logic                            write_n,
   input  logic [DATA_WIDTH-1:0]           writedata,
   output logic [DATA_WIDTH-1:0]           readdata,
   output logic [NUM_WORDS*DATA_WIDTH-1:0] out_port,
   output logic                            out_valid,
   input  logic                            out_ready
);

   localparam logic [ADDR_WIDTH-1:0] CTRL_A = ADDR_WIDTH'(NUM_WORDS);
   localparam logic [ADDR_WIDTH-1:0] STAT_A = ADDR_WIDTH'(NUM_WORDS + 1);

   if ((2 ** ADDR_WIDTH) < (NUM_WORDS + 2)) begin : g_bad_addr
      $error("ADDR_WIDTH too small for NUM_WORDS+2 registers");
   end
   if (DATA_WIDTH < 16) begin : g_bad_data
      $error("DATA_WIDTH must hold the 16-bit STATUS layout");
   end

   logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] stage_q, stage_d;
   logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] port_q, port_d;
   logic                                 valid_q, valid_d;
   logic                                 ovr_q, ovr_d;
   logic                                 ever_q, ever_d;
   logic [7:0]                           cnt_q, cnt_d;

   logic wr, ctrl_wr, commit, clr_stage, clr_ovr, accept, reject;

   assign wr        = chipselect & ~write_n;
   assign ctrl_wr   = wr && (address == CTRL_A);
   assign commit    = ctrl_wr & writedata[0];
   assign clr_stage = ctrl_wr & writedata[1];
   assign clr_ovr   = ctrl_wr & writedata[2];
   // A pending value may be replaced only in the cycle it is consumed.
   assign accept    = commit & (~valid_q | out_ready);
   assign reject    = commit & valid_q & ~out_ready;

   always_comb begin
      stage_d = stage_q;
      for (int k = 0; k < NUM_WORDS; k++) begin
         if (wr && (address == ADDR_WIDTH'(k))) stage_d[k] = writedata;
      end
      if (clr_stage) stage_d = '0;

      port_d  = accept ? stage_q : port_q;
      valid_d = valid_q & ~out_ready;
      if (accept) valid_d = 1'b1;

      ovr_d = ovr_q;
      if (clr_ovr) ovr_d = 1'b0;
      if (reject)  ovr_d = 1'b1;

      ever_d = ever_q | accept;
      cnt_d  = cnt_q + {7'd0, accept};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stage_q <= '0;
         port_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         ever_q  <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         stage_q <= stage_d;
         port_q  <= port_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         ever_q  <= ever_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      readdata = '0;
      if (address == STAT_A) begin
         readdata[0]    = valid_q;
         readdata[1]    = ovr_q;
         readdata[2]    = ever_q;
         readdata[15:8] = cnt_q;
      end
`ifdef SEED_BANK_READBACK_EN
      for (int k = 0; k < NUM_WORDS; k++) begin
         if (address == ADDR_WIDTH'(k)) readdata = stage_q[k];
      end
`endif
   end

   assign out_port  = port_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_crypto_wallet2_nios_po_seed_bank.sv
// Directed vector bench for crypto_wallet2_nios_po_seed_bank.
// Staging readback expectations follow SEED_BANK_READBACK_EN.
module tb_crypto_wallet2_nios_po_seed_bank;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [63:0] out_port;
   logic        out_valid;
   logic        out_ready;

   int errors = 0;
   int checks = 0;

`ifdef SEED_BANK_READBACK_EN
   localparam logic [31:0] RBM = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] RBM = 32'h0;
`endif

   crypto_wallet2_nios_po_seed_bank dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [1:0]  addr;
      logic [31:0] data;
      logic        rdy;
      logic [63:0] e_port;
      logic        e_valid;
      logic [1:0]  rd_addr;
      logic [31:0] e_rd;
   } vec_t;

   vec_t v[20];

   task automatic check(input string name, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic wr, input logic [1:0] a,
                        input logic [31:0] d, input logic rdy);
      @(negedge clk);
      reset      = rst;
      chipselect = wr;
      write_n    = ~wr;
      address    = a;
      writedata  = d;
      out_ready  = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic rd_check(input string name, input logic [1:0] a,
                           input logic [31:0] exp);
      chipselect = 1'b1;
      write_n    = 1'b1;
      address    = a;
      #1;
      check(name, {32'd0, readdata}, {32'd0, exp});
   endtask

   task automatic outs(input string name, input logic [63:0] p,
                       input logic vld);
      check({name, ".port"}, out_port, p);
      check({name, ".valid"}, {63'd0, out_valid}, {63'd0, vld});
   endtask

   localparam logic [63:0] P1 = 64'h01234567_DEADBEEF;
   localparam logic [63:0] P2 = 64'h55555555_AAAAAAAA;
   localparam logic [63:0] P3 = 64'h22222222_11111111;

   initial begin
      reset = 1'b1; chipselect = 1'b0; write_n = 1'b1;
      address = '0; writedata = '0; out_ready = 1'b0;

      //    wr  a  data           rdy port valid rd  exp_rd
      v[0]  = '{1, 0, 32'hDEADBEEF, 0, 64'd0, 0, 3, 32'h000};
      v[1]  = '{1, 1, 32'h01234567, 0, 64'd0, 0, 0, 32'hDEADBEEF & RBM};
      v[2]  = '{1, 2, 32'h1,        0, P1,    1, 3, 32'h105};
      v[3]  = '{1, 2, 32'h1,        0, P1,    1, 3, 32'h107};
      v[4]  = '{1, 2, 32'h4,        0, P1,    1, 3, 32'h105};
      v[5]  = '{1, 0, 32'hAAAAAAAA, 0, P1,    1, 3, 32'h105};
      v[6]  = '{1, 1, 32'h55555555, 0, P1,    1, 1, 32'h55555555 & RBM};
      v[7]  = '{1, 2, 32'h1,        0, P1,    1, 3, 32'h107};
      v[8]  = '{1, 2, 32'h1,        1, P2,    1, 3, 32'h207};
      v[9]  = '{0, 0, 32'h0,        1, P2,    0, 3, 32'h206};
      v[10] = '{1, 2, 32'h4,        0, P2,    0, 3, 32'h204};
      v[11] = '{1, 0, 32'h11111111, 0, P2,    0, 3, 32'h204};
      v[12] = '{1, 1, 32'h22222222, 0, P2,    0, 0, 32'h11111111 & RBM};
      v[13] = '{0, 0, 32'h0,        0, P2,    0, 1, 32'h22222222 & RBM};
      v[14] = '{1, 2, 32'h3,        0, P3,    1, 3, 32'h305};
      v[15] = '{0, 0, 32'h0,        0, P3,    1, 0, 32'h0};
      v[16] = '{0, 0, 32'h0,        0, P3,    1, 1, 32'h0};
      v[17] = '{0, 0, 32'h0,        0, P3,    1, 2, 32'h0};
      v[18] = '{1, 3, 32'hFFFFFFFF, 0, P3,    1, 3, 32'h305};
      v[19] = '{1, 2, 32'h2,        0, P3,    1, 3, 32'h305};

      drive(1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
      drive(1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
      outs("reset", 64'd0, 1'b0);
      rd_check("reset.status", 2'd3, 32'd0);

      for (int i = 0; i < 20; i++) begin
         drive(1'b0, v[i].wr, v[i].addr, v[i].data, v[i].rdy);
         outs($sformatf("vec%0d", i), v[i].e_port, v[i].e_valid);
         rd_check($sformatf("vec%0d.rd", i), v[i].rd_addr, v[i].e_rd);
      end

      // count is 3; staging is zero, so back-to-back commits drive port to 0
      for (int i = 0; i < 252; i++) begin
         drive(1'b0, 1'b1, 2'd2, 32'h1, 1'b1);
      end
      outs("cnt255", 64'd0, 1'b1);
      rd_check("cnt255.status", 2'd3, 32'hFF05);

      drive(1'b0, 1'b1, 2'd2, 32'h1, 1'b1);
      outs("wrap", 64'd0, 1'b1);
      rd_check("wrap.status", 2'd3, 32'h0005);

      // restage, commit, then reset while valid and a commit is presented
      drive(1'b0, 1'b1, 2'd0, 32'hCAFEF00D, 1'b1);
      drive(1'b0, 1'b1, 2'd2, 32'h1, 1'b1);
      outs("restage", 64'h00000000_CAFEF00D, 1'b1);
      rd_check("restage.status", 2'd3, 32'h0105);

      drive(1'b1, 1'b1, 2'd2, 32'h1, 1'b0);
      outs("rst_mid", 64'd0, 1'b0);
      rd_check("rst_mid.status", 2'd3, 32'd0);
      rd_check("rst_mid.stage0", 2'd0, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/crypto_wallet2_nios_po_seed_bank.md
Name: crypto_wallet2_nios_po_seed_bank

Overview:
- Parametrised Avalon-MM slave output port. Successor to the single-word seed PIO.
- Software writes NUM_WORDS staging words, then commits them atomically to a wide out_port.
- A valid/ready handshake hands the committed value to the downstream consumer (TRNG/key-derivation core).
- Status register exposes pending, overrun and a commit counter.

Parameters:
- DATA_WIDTH, 32, width of one Avalon word and one seed slice.
- NUM_WORDS, 2, number of staging words; out_port width = NUM_WORDS*DATA_WIDTH.
- ADDR_WIDTH, 2, Avalon address width; must satisfy 2**ADDR_WIDTH >= NUM_WORDS+2 (elaboration error otherwise).

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- address  in  ADDR_WIDTH  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  DATA_WIDTH  write data.
- readdata  out  DATA_WIDTH  combinational read data.
- out_port  out  NUM_WORDS*DATA_WIDTH  committed seed; word 0 in LSBs.
- out_valid  out  1  committed value awaiting consumer.
- out_ready  in  1  consumer accepts out_port when out_valid=1.

Behaviour:
- Write = chipselect & ~write_n. All state is updated on the clk rising edge. Reset is synchronous and active-high; it overrides any write.
- Address map:
  - 0..NUM_WORDS-1: staging word k, R/W.
  - NUM_WORDS: CTRL, write-only, reads 0. bit0 COMMIT, bit1 CLEAR_STAGE, bit2 CLEAR_OVERRUN. Bits are self-clearing pulses, not stored.
  - NUM_WORDS+1: STATUS, read-only. bit0 out_valid, bit1 overrun, bit2 ever_committed, bits[15:8] commit_count. Other bits 0.
  - Other addresses: reads 0, writes ignored.
- Reset values: all staging words 0, out_port 0, out_valid 0, overrun 0, ever_committed 0, commit_count 0.
- Handshake completes on any cycle with out_valid & out_ready. out_valid then drops next cycle unless a new commit is accepted in the same cycle.
- out_port is stable while out_valid=1 and only changes on an accepted commit.
- COMMIT accepted when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle (back-to-back). On accept, next cycle:
  - out_port = concatenation of current staging words;
  - out_valid=1;
  - ever_committed=1;
  - commit_count += 1, wrapping 255->0.
- COMMIT rejected when out_valid=1 and out_ready=0. On reject: overrun set (sticky), out_port/out_valid/commit_count unchanged.
- CLEAR_STAGE zeroes all staging words. If set in the same write as COMMIT, the commit samples the pre-clear staging values.
- CLEAR_OVERRUN clears overrun. If a rejected COMMIT occurs in the same write, set wins: overrun=1.
- Staging writes while out_valid=1 are allowed and do not affect out_port.
- Latency:
  - staging write to readback: 1 cycle;
  - COMMIT write to out_valid: 1 cycle;
  - out_ready handshake to out_valid low: 1 cycle.
- Reset mid-handshake drops out_valid immediately on that edge; the consumer must treat it as abandoned.

Optional Feature:
- Macro: SEED_BANK_READBACK_EN.
- Defined: staging words read back their contents.
- Undefined (default, secure build): staging-word reads return 0, so seed material is never visible on the bus. CTRL/STATUS reads are unaffected. Write behaviour is identical in both builds.

Test Plan:
- Reset, then read STATUS -> 0x00000000; out_port=0, out_valid=0.
- Write word0=0xDEADBEEF, word1=0x01234567, CTRL=0x1, out_ready=0 -> next cycle out_port=0x01234567DEADBEEF, out_valid=1, STATUS=0x00000105.
- With out_valid=1 and out_ready=0, write CTRL=0x1 -> overrun=1, out_port unchanged, commit_count stays 1. Then write CTRL=0x4 -> STATUS bit1=0.
- Stage 0xAAAAAAAA/0x55555555 and COMMIT in the same cycle out_ready=1 with pending valid -> out_valid stays 1, out_port=0x55555555AAAAAAAA, commit_count=2, overrun unchanged.
- Write CTRL=0x3 after staging 0x11111111/0x22222222 -> out_port=0x2222222211111111; staging words now 0 (read 0 in both builds).
- 256 accepted commits with out_ready=1 -> commit_count wraps to 0, ever_committed=1. Assert reset during out_valid=1 -> out_valid=0 next edge.
